// File: rtl/ncl_sync_source_if.sv
// Bus between the clocked word source, the NCL token producer and the first NCL stage.
// slave is the producer's view; master is the environment's view.
interface ncl_sync_source_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] ncl_t;
  logic [WIDTH-1:0] ncl_f;
  logic             ack_in;

  modport slave (
    input  in_valid,
    input  in_data,
    input  ack_in,
    output in_ready,
    output ncl_t,
    output ncl_f
  );

  modport master (
    output in_valid,
    output in_data,
    output ack_in,
    input  in_ready,
    input  ncl_t,
    input  ncl_f
  );
endinterface

// File: rtl/ncl_sync_source.sv
// Clocked producer feeding the first NCL stage: one DATA wavefront then one NULL per word,
// paced by the stage's completion through a reset-to-busy synchronizer.
//
//   state   | meaning
//   idle    | rails NULL, accept a word once the pipeline reads NULL
//   data    | rails hold the word, wait for completion to rise
//   rtz     | rails NULL, wait for completion to fall
module ncl_sync_source #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             init_n,
  ncl_sync_source_if.slave bus,
  output logic             busy,
  output logic [CNT_W-1:0] tok_count
);

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_data = 2'd1,
    st_rtz  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic [WIDTH-1:0]       rail_t;
  logic [WIDTH-1:0]       rail_f;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ready_c;
  logic                   busy_c;
  logic                   accept;
  logic                   retire;

  // Reset to all-ones so the pipeline reads as busy until real NULL propagates through.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ack_in};
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!init_n) begin
      state <= st_idle;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      st_idle: if (accept) state_nxt = st_data;
      st_data: if (ack_s)  state_nxt = st_rtz;
      st_rtz:  if (!ack_s) state_nxt = st_idle;
      default: state_nxt = st_idle;
    endcase
  end

  always_comb begin
    ready_c = 1'b0;
    busy_c  = 1'b1;
    accept  = 1'b0;
    retire  = 1'b0;
    case (state)
      st_idle: begin
        busy_c  = 1'b0;
        ready_c = !ack_s;
        accept  = !ack_s && bus.in_valid;
      end
      st_data: retire = ack_s;
      default: ;
    endcase
  end

  // Rails come straight from these flops so every pair switches cleanly on one edge.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      rail_t <= '0;
      rail_f <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      rail_t <= bus.in_data;
      rail_f <= ~bus.in_data;
    end else if (retire) begin
      rail_t <= '0;
      rail_f <= '0;
      cnt_q  <= cnt_q + CNT_ONE;
    end
  end

  assign bus.in_ready = ready_c;
  assign bus.ncl_t    = rail_t;
  assign bus.ncl_f    = rail_f;
  assign busy         = busy_c;
  assign tok_count    = cnt_q;

endmodule

// File: tb/tb_ncl_sync_source.sv
// Directed and random bench for ncl_sync_source with a behavioural reference, a 4-stage NCL
// pipeline model and a narrow-counter instance for wrap-around.
module tb_ncl_sync_source;
  localparam int W  = 8;
  localparam int NS = 2;

  logic        clk = 1'b0;
  logic        init_n = 1'b0;
  logic        busy;
  logic        wbusy;
  logic [15:0] tok_count;
  logic [3:0]  wcnt;

  ncl_sync_source_if #(.WIDTH(W)) bus ();
  ncl_sync_source_if #(.WIDTH(W)) wbus ();

  ncl_sync_source #(.WIDTH(W), .SYNC_STAGES(NS), .CNT_W(16)) dut (
    .clk(clk), .init_n(init_n), .bus(bus), .busy(busy), .tok_count(tok_count)
  );

  ncl_sync_source #(.WIDTH(W), .SYNC_STAGES(NS), .CNT_W(4)) dut_wrap (
    .clk(clk), .init_n(init_n), .bus(wbus), .busy(wbusy), .tok_count(wcnt)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // reference: phase 0 idle / 1 data outstanding / 2 returning to zero
  int          m_ph = 0;
  logic [7:0]  m_t = '0;
  logic [7:0]  m_f = '0;
  logic [15:0] m_cnt = '0;
  bit          ackq[$];
  bit          m_acks = 1'b1;

  // ack source: 0 manual, 1 delayed stage, 2 pipeline, 3 random lag
  int amode = 0;
  // word source: 0 manual, 1 queue, 2 random
  int umode = 0;
  int dly = 0;
  bit wrap_en = 1'b0;

  bit         st_d[5];
  logic [7:0] st_v[5];
  logic [7:0] rxq[$];
  logic [7:0] txq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit         rdy;
    bit         fire;
    bit         acks_old;
    bit         samp;
    bit         rd;
    bit         rn;
    bit         ind;
    bit         inn;
    logic [7:0] v;
    logic [7:0] inv;
    rdy      = (m_ph == 0) && !m_acks;
    fire     = bus.in_valid && rdy;
    acks_old = m_acks;
    samp     = bus.ack_in;
    v        = bus.in_data;
    @(posedge clk);
    #1;
    if (!init_n) begin
      m_ph  = 0;
      m_t   = '0;
      m_f   = '0;
      m_cnt = '0;
      ackq.delete();
      for (int i = 0; i < NS; i++) ackq.push_back(1'b1);
    end else begin
      ackq.push_back(samp);
      if (ackq.size() > NS) void'(ackq.pop_front());
      case (m_ph)
        0: if (fire) begin m_ph = 1; m_t = v; m_f = ~v; end
        1: if (acks_old) begin m_ph = 2; m_t = '0; m_f = '0; m_cnt = m_cnt + 16'd1; end
        default: if (!acks_old) m_ph = 0;
      endcase
    end
    m_acks = ackq[0];

    chk("ncl_t", 32'(bus.ncl_t), 32'(m_t));
    chk("ncl_f", 32'(bus.ncl_f), 32'(m_f));
    chk("tok_count", 32'(tok_count), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(m_ph != 0));
    chk("in_ready", 32'(bus.in_ready), 32'((m_ph == 0) && !m_acks));
    chk("ready_outside_idle", 32'(bus.in_ready & busy), 32'd0);
    chk("pair_1_1", 32'(bus.ncl_t & bus.ncl_f), 32'd0);
    chk("wrap_pair_1_1", 32'(wbus.ncl_t & wbus.ncl_f), 32'd0);

    rd = ((bus.ncl_t | bus.ncl_f) == 8'hFF);
    rn = (bus.ncl_t == 8'h00) && (bus.ncl_f == 8'h00);
    case (amode)
      1: begin
        if (rd) begin
          dly++;
          if (dly >= 3) bus.ack_in = 1'b1;
        end else begin
          dly = 0;
          bus.ack_in = 1'b0;
        end
      end
      2: begin
        if (st_d[4] != st_d[3]) begin
          st_d[4] = st_d[3];
          if (st_d[3]) rxq.push_back(st_v[3]);
        end
        for (int i = 3; i >= 0; i--) begin
          if (i == 0) begin
            ind = rd; inn = rn; inv = bus.ncl_t;
          end else begin
            ind = st_d[i-1]; inn = !st_d[i-1]; inv = st_v[i-1];
          end
          if (!st_d[i] && ind && !st_d[i+1]) begin
            st_d[i] = 1'b1;
            st_v[i] = inv;
          end else if (st_d[i] && inn && st_d[i+1]) begin
            st_d[i] = 1'b0;
          end
        end
        bus.ack_in = st_d[0];
      end
      3: begin
        if (rd && !bus.ack_in && $urandom_range(0, 2) == 0) bus.ack_in = 1'b1;
        else if (rn && bus.ack_in && $urandom_range(0, 2) == 0) bus.ack_in = 1'b0;
      end
      default: ;
    endcase

    if (umode == 1) begin
      if (fire) void'(txq.pop_front());
      bus.in_valid = (txq.size() > 0);
      if (txq.size() > 0) bus.in_data = txq[0];
    end else if (umode == 2) begin
      if (fire) bus.in_valid = 1'b0;
      if (!bus.in_valid && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
      end
    end

    wbus.ack_in   = ((wbus.ncl_t | wbus.ncl_f) == 8'hFF);
    wbus.in_valid = wrap_en;
    wbus.in_data  = 8'h5A;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seq[$];
    logic [3:0] prev;

    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h33;
    bus.ack_in    = 1'b0;
    wbus.in_valid = 1'b0;
    wbus.in_data  = 8'h5A;
    wbus.ack_in   = 1'b0;
    for (int i = 0; i < 5; i++) begin st_d[i] = 1'b0; st_v[i] = '0; end

    // reset with a word on offer and the pipeline reading NULL
    init_n = 1'b0;
    repeat (3) tick();
    chk("rst_rails", 32'(bus.ncl_t | bus.ncl_f), 32'd0);
    chk("rst_tok_count", 32'(tok_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    init_n = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin tick(); n++; end
    chk("ready_after_reset_edges", 32'(n), 32'(NS));

    // single token against a stage acking 3 cycles after DATA
    amode = 1; dly = 0;
    bus.in_data = 8'hA5; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("single_t", 32'(bus.ncl_t), 32'hA5);
    chk("single_f", 32'(bus.ncl_f), 32'h5A);
    n = 0;
    while (bus.ncl_t != 8'h00 && n < 30) begin tick(); n++; end
    chk("single_null_t", 32'(bus.ncl_t), 32'd0);
    chk("single_null_f", 32'(bus.ncl_f), 32'd0);
    chk("single_tok_count", 32'(tok_count), 32'd1);
    n = 0;
    while (!bus.in_ready && n < 30) begin tick(); n++; end
    chk("single_back_idle", 32'(bus.in_ready), 32'd1);

    // 16 words through the 4-stage pipeline
    init_n = 1'b0;
    tick();
    init_n = 1'b1;
    amode = 2;
    bus.ack_in = 1'b0;
    for (int i = 0; i < 5; i++) st_d[i] = 1'b0;
    rxq.delete();
    for (int i = 0; i < 16; i++) txq.push_back(8'(i));
    bus.in_data = txq[0]; bus.in_valid = 1'b1;
    umode = 1;
    n = 0;
    while (!(rxq.size() == 16 && bus.in_ready) && n < 600) begin tick(); n++; end
    umode = 0;
    bus.in_valid = 1'b0;
    chk("b2b_received", 32'(rxq.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      chk("b2b_word", (i < rxq.size()) ? 32'(rxq[i]) : 32'hFFFF_FFFF, 32'(i));
    chk("b2b_tok_count", 32'(tok_count), 32'd16);

    // stall: completion held high for 50 cycles after a token
    amode = 0;
    bus.ack_in = 1'b0;
    bus.in_data = 8'h3C; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("stall_first_t", 32'(bus.ncl_t), 32'h3C);
    bus.ack_in = 1'b1;
    n = 0;
    while (bus.ncl_t != 8'h00 && n < 20) begin tick(); n++; end
    bus.in_data = 8'hC3; bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("stall_rails_null", 32'(bus.ncl_t | bus.ncl_f), 32'd0);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.ack_in = 1'b0;
    n = 0;
    while (bus.ncl_t == 8'h00 && n < 20) begin tick(); n++; end
    bus.in_valid = 1'b0;
    chk("stall_accept_edge", 32'(n), 32'(NS + 2));
    chk("stall_second_t", 32'(bus.ncl_t), 32'hC3);
    bus.ack_in = 1'b1;
    n = 0;
    while (bus.ncl_t != 8'h00 && n < 20) begin tick(); n++; end
    bus.ack_in = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 20) begin tick(); n++; end

    // reset on the very edge that would have retired the token
    bus.in_data = 8'hFF; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("mid_t", 32'(bus.ncl_t), 32'hFF);
    bus.ack_in = 1'b1;
    tick();
    tick();
    chk("mid_still_data", 32'(bus.ncl_t), 32'hFF);
    chk("mid_count_before", 32'(tok_count), 32'd18);
    init_n = 1'b0;
    tick();
    chk("mid_rst_t", 32'(bus.ncl_t), 32'd0);
    chk("mid_rst_f", 32'(bus.ncl_f), 32'd0);
    chk("mid_rst_tok_count", 32'(tok_count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    init_n = 1'b1;
    bus.ack_in = 1'b0;
    tick();
    chk("mid_no_increment", 32'(tok_count), 32'd0);
    n = 0;
    while (!bus.in_ready && n < 20) begin tick(); n++; end

    // random words against a randomly lagging completion
    amode = 3; umode = 2;
    repeat (800) tick();
    umode = 0;

    // wrap of the 4-bit counter instance
    init_n = 1'b0;
    tick();
    init_n = 1'b1;
    wrap_en = 1'b1;
    prev = wcnt;
    n = 0;
    while (seq.size() < 17 && n < 400) begin
      tick();
      n++;
      if (wcnt != prev) begin
        seq.push_back(int'(wcnt));
        prev = wcnt;
      end
    end
    wrap_en = 1'b0;
    chk("wrap_tokens", 32'(seq.size()), 32'd17);
    for (int i = 0; i < seq.size(); i++)
      chk("wrap_step", 32'(seq[i]), 32'((i + 1) % 16));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ncl_sync_source.md
# ncl_sync_source

Clocked producer that sits directly upstream of the first single-rail NCL pipeline stage and replaces the free-running auto-producer. It accepts words from synchronous logic over a valid/ready handshake and emits each as one dual-rail NCL DATA wavefront followed by a NULL wavefront. It paces itself from the first stage's asynchronous completion signal through a synchronizer. It is the boundary block between the clocked test/system side and the clockless pipeline.

## Interface
Parameters:
- WIDTH, 8, data bits per token; one rail pair per bit.
- SYNC_STAGES, 2, flops in the ack_in synchronizer; must be at least 2.
- CNT_W, 16, width of the token counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- init_n  input  1  synchronous, active-low reset.
- in_valid  input  1  upstream word available.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  word to be tokenized.
- ncl_t  output  WIDTH  true rails to the first pipeline stage.
- ncl_f  output  WIDTH  false rails to the first pipeline stage.
- ack_in  input  1  completion from the first stage; asynchronous. High means the stage holds DATA. Low means it holds NULL.
- busy  output  1  high whenever state is not IDLE.
- tok_count  output  CNT_W  number of tokens acknowledged by the pipeline.

## Operation
- The state machine has three states: IDLE, DATA and RTZ.
- **Reset (init_n=0 at an edge):**
  - State goes to IDLE.
  - ncl_t and ncl_f go to all-0 (NULL).
  - tok_count goes to 0.
  - All synchronizer flops go to 1, which reads as "pipeline busy".
  - in_ready=0 and busy=0.
  - Reset applies from any state, including mid-token. The downstream pipeline is reinitialised by its own init; this block guarantees only NULL on its outputs.
- **ack_s** is the last synchronizer flop. All decisions use ack_s, never ack_in directly.
- **IDLE:**
  - Rails are NULL.
  - in_ready = (ack_s==0). This is combinational from state and ack_s.
  - On an edge with in_valid & in_ready, the block latches in_data into the rail registers and enters DATA. For each bit i: ncl_t[i]=in_data[i] and ncl_f[i]=~in_data[i].
- **DATA:**
  - Rails hold the latched word. in_ready=0.
  - On an edge with ack_s==1, the block clears all rails to NULL, increments tok_count and enters RTZ.
- **RTZ:**
  - Rails are NULL. in_ready=0.
  - On an edge with ack_s==0, the block enters IDLE.
- **Rail encoding:**
  - The rails are driven directly from flops, with no logic after the registers.
  - Every transition is NULL→DATA or DATA→NULL, with all bits changing on the same edge.
  - A pair never shows 1/1.
  - Only one DATA wavefront is ever outstanding.
- **tok_count** wraps modulo 2^CNT_W, so all-ones + 1 → 0.
- **Simultaneous events:**
  - in_valid is ignored outside IDLE. Upstream must hold the word until in_ready.
  - If ack_s is still 1 on entry to IDLE, in_ready stays 0 until ack_s falls.
  - After reset, no word is accepted until ack_s reads 0, i.e. at least SYNC_STAGES cycles.

## Timing
- Accept at edge k → DATA is visible on the rails after edge k.
- ack_in rising → ack_s rises after SYNC_STAGES edges. At the next edge the rails go NULL and tok_count increments.
- ack_in falling → after SYNC_STAGES edges, IDLE is entered on the following edge. in_ready is asserted in that same cycle.
- Minimum token period with an instantaneous pipeline and SYNC_STAGES=2 is 1 (accept) + 2 + 1 + 2 + 1 = 7 cycles, plus the pipeline's own forward and return delays.
- ack_in must be glitch-free per NCL completion semantics. Metastability is handled only by the synchronizer.

## Test plan
- **Reset values:** assert init_n=0 for 3 cycles, with ack_in=0 and in_valid=1. Required response:
  - During reset: rails=0, tok_count=0, busy=0, in_ready=0.
  - After release: in_ready=1 appears no earlier than SYNC_STAGES cycles.
- **Single token:** in_data=8'hA5 against a behavioural stage that raises ack_in 3 cycles after rails become DATA. Required response:
  - ncl_t=8'hA5 and ncl_f=8'h5A.
  - Rails then return to 8'h00/8'h00 and tok_count=1.
  - No 1/1 pair at any edge.
- **Back-to-back:** drive 16 words 0x00..0x0F through the real 4-stage pipeline model with the sink auto-consuming. Required response:
  - Every word is received once and in order, and tok_count=16.
  - in_ready is never high outside IDLE.
- **Stall:** hold ack_in=1 for 50 cycles after one DATA. Required response:
  - Rails stay NULL and in_ready=0 throughout.
  - A second in_valid is not accepted until ack_in falls and SYNC_STAGES+1 edges pass.
- **Reset mid-token:** pulse init_n=0 for one edge while in DATA with 8'hFF on ncl_t. Required response:
  - At that edge the rails go to 0/0, tok_count goes to 0 and state goes to IDLE.
  - No increment occurs.
- **Counter wrap:** set CNT_W=4 and send 17 tokens. Required response: tok_count runs 15 → 0 → 1.
